// File: rtl/vram_arbiter.sv
// Three-way arbiter for the single-port 8 KB VRAM: video has fixed priority,
// CPU and DMA share round-robin, and a starvation guard lets them pre-empt video.
module vram_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic [7:0]  vid_data,
    output logic        vid_valid,
    output logic        vid_miss,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic [12:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [12:0] ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic        vid_valid_q, vid_valid_d;
    logic        vid_miss_q, vid_miss_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic        rr_q, rr_d;
    logic [3:0]  wait_cpu_q, wait_cpu_d;
    logic [3:0]  wait_dma_q, wait_dma_d;
    tag_e        tag1_q, tag1_d;
    tag_e        tag2_q, tag2_d;

    logic cpu_elig, dma_elig, cpu_force, dma_force;
    logic grant_vid, grant_cpu, grant_dma;

    // A requester stays ineligible until the cycle after its ack, so a req
    // still held during the ack cycle is not mistaken for a new one.
    always_comb begin
        cpu_elig  = cpu_req && (tag1_q != TAG_CPU) && (tag2_q != TAG_CPU) && !cpu_ack_q;
        dma_elig  = dma_req && !dma_ack_q;
        cpu_force = cpu_elig && (wait_cpu_q == MAX_WAIT_C);
        dma_force = dma_elig && (wait_dma_q == MAX_WAIT_C);
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (cpu_force && dma_force) begin
            grant_cpu = !rr_q;
            grant_dma = rr_q;
        end else if (cpu_force) begin
            grant_cpu = 1'b1;
        end else if (dma_force) begin
            grant_dma = 1'b1;
        end else if (vid_req) begin
            grant_vid = 1'b1;
        end else if (cpu_elig && dma_elig) begin
            grant_cpu = !rr_q;
            grant_dma = rr_q;
        end else begin
            grant_cpu = cpu_elig;
            grant_dma = dma_elig;
        end
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        rr_d        = rr_q;
        tag1_d      = TAG_NONE;
        tag2_d      = tag1_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        vid_miss_d  = vid_req && (cpu_force || dma_force);
        vid_valid_d = (tag2_q == TAG_VID);
        vid_data_d  = vid_data_q;
        cpu_rdata_d = cpu_rdata_q;

        // Read data returns two edges after the grant; the tag says whose it is.
        if (tag2_q == TAG_VID) begin
            vid_data_d = ram_rdata;
        end else if (tag2_q == TAG_CPU) begin
            cpu_rdata_d = ram_rdata;
            cpu_ack_d   = 1'b1;
        end

        if (grant_vid) begin
            ram_addr_d = vid_addr;
            tag1_d     = TAG_VID;
        end else if (grant_cpu) begin
            ram_addr_d = cpu_addr;
            rr_d       = 1'b1;
            if (cpu_we) begin
                ram_we_d    = 1'b1;
                ram_wdata_d = cpu_wdata;
                cpu_ack_d   = 1'b1;
            end else begin
                tag1_d = TAG_CPU;
            end
        end else if (grant_dma) begin
            ram_addr_d  = dma_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = dma_wdata;
            dma_ack_d   = 1'b1;
            rr_d        = 1'b0;
        end

        wait_cpu_d = wait_cpu_q;
        if (!cpu_req || grant_cpu) begin
            wait_cpu_d = 4'd0;
        end else if (cpu_elig && grant_vid && wait_cpu_q != 4'hF) begin
            wait_cpu_d = wait_cpu_q + 4'd1;
        end

        wait_dma_d = wait_dma_q;
        if (!dma_req || grant_dma) begin
            wait_dma_d = 4'd0;
        end else if (dma_elig && grant_vid && wait_dma_q != 4'hF) begin
            wait_dma_d = wait_dma_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_miss_q  <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            rr_q        <= 1'b0;
            wait_cpu_q  <= '0;
            wait_dma_q  <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            vid_miss_q  <= vid_miss_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            rr_q        <= rr_d;
            wait_cpu_q  <= wait_cpu_d;
            wait_dma_q  <= wait_dma_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign vid_miss  = vid_miss_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 8 KB VRAM (13-bit address, 8-bit data, one-cycle synchronous read) among three requesters: the video scan-out fetch, the CPU bus and the LCD DMA engine. Video has fixed priority. CPU and DMA alternate round-robin, and a starvation guard lets a blocked CPU/DMA request pre-empt video. The block sits between the VRAM macro and the video, CPU and DMA blocks.

## Interface
Parameters:
- MAX_WAIT, 4: consecutive video-blocked cycles after which a pending CPU/DMA request pre-empts video (legal 1–15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- vid_req  in  1  video read request, single-cycle, no handshake
- vid_addr  in  13  video read address
- vid_data  out  8  video read data
- vid_valid  out  1  one-cycle pulse: vid_data holds data for a granted vid_req
- vid_miss  out  1  one-cycle pulse: a vid_req was pre-empted and will get no data
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  13  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid with cpu_ack on reads
- cpu_ack  out  1  one-cycle completion pulse
- dma_req  in  1  DMA write request, held until dma_ack
- dma_addr  in  13  DMA write address
- dma_wdata  in  8  DMA write data
- dma_ack  out  1  one-cycle completion pulse
- ram_addr  out  13  VRAM address (registered)
- ram_we  out  1  VRAM write enable (registered)
- ram_wdata  out  8  VRAM write data (registered)
- ram_rdata  in  8  VRAM read data, valid the cycle after ram_addr is sampled

## Operation
- One grant per cycle, decided on requests sampled at clock edge E0. The winner drives ram_addr, ram_we and ram_wdata through registers from E0 on.
- Priority:
  - A forced CPU/DMA grant (starvation guard) wins first.
  - Otherwise vid_req wins.
  - Otherwise the round-robin winner among CPU and DMA. Eligible means req is high and no transaction is in flight.
- Round-robin: rr=0 prefers CPU, rr=1 prefers DMA. After each CPU or DMA grant, rr points to the other requester. Video grants leave rr unchanged.
- Starvation guard:
  - Counters wait_cpu and wait_dma (4 bits, saturating).
  - A counter increments each cycle its requester is eligible but loses to video.
  - It clears on that requester's grant or when its req is low.
  - At count == MAX_WAIT the requester is forced. If both are forced, rr decides.
  - A pre-empted vid_req produces vid_miss.
- In-flight tracking: a requester is not regranted until its ack has been issued. A req held high during the ack cycle is treated as a new request from the next cycle.
- Idle cycle: ram_we=0; ram_addr and ram_wdata hold their previous values.
- Read data mux: a 2-bit tag pipeline records the owner of each read. ram_rdata is captured into vid_data or cpu_rdata only; the other output holds.

## Timing
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, vid_data=0, cpu_rdata=0, all pulses 0, rr=0, wait counters 0, no transactions in flight.
- Video read: vid_req sampled at E0 → vid_valid high in the cycle after E2, with data at vid_addr. Latency is 2 edges, fixed.
- Video miss: vid_miss pulses in the cycle after E0.
- CPU/DMA write: grant at E0 → ram_we high in the cycle after E0, with ack pulsing in that same cycle. The RAM write lands at E1.
- CPU read: grant at E0 → cpu_ack and cpu_rdata in the cycle after E2.
- Back-to-back video reads at every edge are sustained: full throughput, pipelined.
- A write followed by a read of the same address in the next grant returns the new data.
- Reset mid-operation: in-flight transactions are discarded and no ack, vid_valid or vid_miss is issued for them. Requesters must re-issue.

## Test plan
- Reset then idle: all outputs at reset values and ram_we=0 for 10 cycles.
- Video alone: vid_req every cycle, addresses 0x0000..0x000F over a preloaded ramp → vid_valid every cycle from the 3rd edge on, data = address low byte, no vid_miss.
- CPU vs DMA contention: both request simultaneously and continuously → grants alternate starting with CPU. cpu_ack and dma_ack never coincide.
- Starvation, MAX_WAIT=4: vid_req held high, cpu_req (read 0x1234) raised → vid_miss once, 4 cycles after cpu_req; cpu_ack 2 cycles later; video resumes.
- Write/read coherency: CPU writes 0xA5 to 0x0100, then reads 0x0100 → cpu_rdata=0xA5 with cpu_ack.
- Reset asserted one cycle after a CPU read grant → no cpu_ack. After reset, the re-issued read completes normally.
